// File: rtl/decoder_pkg.sv
// decoder_pkg: shared opcodes, operand-source, branch and ALU codes for the instruction decoder
package decoder_pkg;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [2:0] LHS_RS1  = 3'd0;
    localparam logic [2:0] LHS_IMM  = 3'd1;
    localparam logic [2:0] LHS_PC   = 3'd4;
    localparam logic [1:0] RHS_RS2  = 2'd0;
    localparam logic [1:0] RHS_IMM  = 2'd1;
    localparam logic [1:0] RHS_FOUR = 2'd3;

    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LTU = 3'd2;
    localparam logic [2:0] BR_LT  = 3'd3;
    localparam logic [2:0] BR_GEU = 3'd4;
    localparam logic [2:0] BR_GE  = 3'd5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] lhs;
        logic [1:0] rhs;
        logic [3:0] alu;
        logic       word_op;
        logic       wr_rf;
        logic       wr_ram;
        logic       rd_ram;
        logic [2:0] mem_width;
        logic       is_branch;
        logic [2:0] br_cond;
        logic       is_jump;
        logic       jump_mode;
        logic       invalid;
    } dec_t;

    function automatic logic [2:0] branch_cond(input logic [2:0] f3);
        return f3 == 3'b001 ? BR_NE  :
               f3 == 3'b100 ? BR_LT  :
               f3 == 3'b101 ? BR_GE  :
               f3 == 3'b110 ? BR_LTU :
               f3 == 3'b111 ? BR_GEU : BR_EQ;
    endfunction
endpackage

// File: rtl/instruction_decode_core.sv
// instruction_decode_core: purely combinational decode of one instruction into control fields
module instruction_decode_core
    import decoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction_i,
    output dec_t            dec_o,
    output logic [XLEN-1:0] imm_o
);
    localparam bit RV64 = (XLEN == 64);

    logic [31:0] in;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic        shamt_bad, shamtw_bad, r_bad, ok;
    dec_t        dec;

    assign in    = instruction_i;
    assign op    = in[6:0];
    assign f3    = in[14:12];
    assign f7    = in[31:25];
    assign imm_i = {{20{in[31]}}, in[31:20]};
    assign imm_s = {{20{in[31]}}, in[31:25], in[11:7]};
    assign imm_b = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    assign imm_u = {in[31:12], 12'b0};
    assign imm_j = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};

    // RV64 shifts take a 6-bit shamt, so bit 25 is only a legality check on RV32
    assign shamt_bad  = (f7[6:1] != 6'b0 && !(f7[6:1] == 6'b010000 && f3 == 3'b101)) || (!RV64 && f7[0]);
    assign shamtw_bad = f7 != 7'b0 && !(f7 == 7'b0100000 && f3 == 3'b101);
    assign r_bad      = f7 != 7'b0 && !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

    // classify the opcode, then kill all side effects of anything undefined
    always_comb begin
        dec   = '0;
        imm32 = '0;
        ok    = 1'b0;
        case (op)
            OPC_LUI:    begin ok = 1'b1; dec.lhs = LHS_IMM; dec.rhs = RHS_IMM; dec.wr_rf = 1'b1; imm32 = imm_u; end
            OPC_AUIPC:  begin ok = 1'b1; dec.lhs = LHS_PC; dec.rhs = RHS_IMM; dec.wr_rf = 1'b1; imm32 = imm_u; end
            OPC_JAL:    begin ok = 1'b1; dec.lhs = LHS_PC; dec.rhs = RHS_FOUR; dec.wr_rf = 1'b1; dec.is_jump = 1'b1; imm32 = imm_j; end
            OPC_JALR:   begin ok = f3 == 3'b000; dec.lhs = LHS_PC; dec.rhs = RHS_FOUR; dec.wr_rf = 1'b1; dec.is_jump = 1'b1; dec.jump_mode = 1'b1; imm32 = imm_i; end
            OPC_BRANCH: begin ok = f3[2:1] != 2'b01; dec.is_branch = 1'b1; dec.br_cond = branch_cond(f3); imm32 = imm_b; end
            OPC_LOAD:   begin ok = f3 != 3'b111 && (RV64 || (f3 != 3'b011 && f3 != 3'b110)); dec.rd_ram = 1'b1; dec.wr_rf = 1'b1; dec.rhs = RHS_IMM; dec.mem_width = f3; imm32 = imm_i; end
            OPC_STORE:  begin ok = !f3[2] && (RV64 || f3 != 3'b011); dec.wr_ram = 1'b1; dec.rhs = RHS_IMM; dec.mem_width = f3; imm32 = imm_s; end
            OPC_OP_IMM: begin ok = !(f3 == 3'b001 || f3 == 3'b101) || !shamt_bad; dec.wr_rf = 1'b1; dec.rhs = RHS_IMM; dec.alu = {f3 == 3'b101 && in[30], f3}; imm32 = imm_i; end
            OPC_OP:     begin ok = !r_bad; dec.wr_rf = 1'b1; dec.alu = {in[30], f3}; end
            OPC_FENCE:  ok = 1'b1;
            OPC_OP_IMM_32: begin ok = RV64 && (f3 == 3'b000 || ((f3 == 3'b001 || f3 == 3'b101) && !shamtw_bad)); dec.word_op = 1'b1; dec.wr_rf = 1'b1; dec.rhs = RHS_IMM; dec.alu = {f3 == 3'b101 && in[30], f3}; imm32 = imm_i; end
            OPC_OP_32:  begin ok = RV64 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) && !r_bad; dec.word_op = 1'b1; dec.wr_rf = 1'b1; dec.alu = {in[30], f3}; end
            default:    ok = 1'b0;
        endcase
        dec.rd  = in[11:7];
        dec.rs1 = in[19:15];
        dec.rs2 = in[24:20];
        if (!ok) begin
            dec.wr_rf     = 1'b0;
            dec.wr_ram    = 1'b0;
            dec.rd_ram    = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
        end
        dec.invalid = !ok;
        if (dec.rd == 5'd0) dec.wr_rf = 1'b0;
    end

    assign dec_o = dec;
    assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/pipelined_instruction_decoder.sv
// pipelined_instruction_decoder: decode stage with a two-entry skid buffer and invalid-instruction counter
module pipelined_instruction_decoder
    import decoder_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Flush,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [31:0]            Instruction,
    input  logic [XLEN-1:0]        InPC,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [XLEN-1:0]        OutPC,
    output logic [4:0]             OutRD,
    output logic [4:0]             OutRS1,
    output logic [4:0]             OutRS2,
    output logic [XLEN-1:0]        OutImmediate,
    output logic [2:0]             OutLHSsource,
    output logic [1:0]             OutRHSsource,
    output logic [3:0]             OutALUOperation,
    output logic                   OutWordOp,
    output logic                   OutWritesRegisterFile,
    output logic                   OutWritesRam,
    output logic                   OutReadsRam,
    output logic [2:0]             OutMemWidth,
    output logic                   OutIsBranch,
    output logic [2:0]             OutBranchCondition,
    output logic                   OutIsJump,
    output logic                   OutJumpMode,
    output logic                   OutInvalid,
    output logic [COUNT_WIDTH-1:0] InvalidCount
);
    typedef struct packed {
        dec_t            dec;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    dec_t                   dec;
    logic [XLEN-1:0]        imm;
    entry_t                 in_e, out_q, out_d, skid_q, skid_d;
    logic                   out_valid_q, out_valid_d, skid_full_q, skid_full_d, in_ready_q;
    logic                   accept, pop;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    instruction_decode_core #(.XLEN(XLEN)) u_core (
        .instruction_i(Instruction),
        .dec_o        (dec),
        .imm_o        (imm)
    );

    assign in_e   = {dec, imm, InPC};
    assign accept = InValid && in_ready_q && !Flush;
    assign pop    = out_valid_q && OutReady;

    // skid buffer steering: skid drains first, new data bypasses to output when the skid is empty
    always_comb begin
        out_d       = pop && skid_full_q ? skid_q : (accept && (!out_valid_q || pop)) ? in_e : out_q;
        skid_d      = accept && out_valid_q && !pop ? in_e : skid_q;
        out_valid_d = !Flush && (accept || skid_full_q || (out_valid_q && !pop));
        skid_full_d = !Flush && ((accept && out_valid_q && !pop) || (skid_full_q && !pop));
        cnt_d       = accept && dec.invalid && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
    end

    // state registers; InReady is registered as the inverse of the next skid occupancy
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= !skid_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign InReady               = in_ready_q;
    assign OutValid              = out_valid_q;
    assign OutPC                 = out_q.pc;
    assign OutImmediate          = out_q.imm;
    assign OutRD                 = out_q.dec.rd;
    assign OutRS1                = out_q.dec.rs1;
    assign OutRS2                = out_q.dec.rs2;
    assign OutLHSsource          = out_q.dec.lhs;
    assign OutRHSsource          = out_q.dec.rhs;
    assign OutALUOperation       = out_q.dec.alu;
    assign OutWordOp             = out_q.dec.word_op;
    assign OutWritesRegisterFile = out_q.dec.wr_rf;
    assign OutWritesRam          = out_q.dec.wr_ram;
    assign OutReadsRam           = out_q.dec.rd_ram;
    assign OutMemWidth           = out_q.dec.mem_width;
    assign OutIsBranch           = out_q.dec.is_branch;
    assign OutBranchCondition    = out_q.dec.br_cond;
    assign OutIsJump             = out_q.dec.is_jump;
    assign OutJumpMode           = out_q.dec.jump_mode;
    assign OutInvalid            = out_q.dec.invalid;
    assign InvalidCount          = cnt_q;
endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// tb_pipelined_instruction_decoder: directed checks of an RV32 (4-bit counter) and an RV64 decoder fed in lockstep
module tb_pipelined_instruction_decoder;
    logic        Clock = 1'b0;
    logic        Reset, Flush, InValid, OutReady;
    logic [31:0] Instruction;
    logic [63:0] pc;
    int          nvec = 0;
    int          nfail = 0;

    logic        a_in_ready, a_out_valid, a_wo, a_wr, a_wm, a_rr, a_br, a_j, a_jm, a_inv;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_lhs, a_mw, a_bc;
    logic [1:0]  a_rhs;
    logic [3:0]  a_alu, a_cnt;

    logic        b_in_ready, b_out_valid, b_wo, b_wr, b_wm, b_rr, b_br, b_j, b_jm, b_inv;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_lhs, b_mw, b_bc;
    logic [1:0]  b_rhs;
    logic [3:0]  b_alu;
    logic [15:0] b_cnt;

    typedef struct packed {
        logic [31:0] ins;
        logic        ainv, binv;
        logic [31:0] imm;
        logic [2:0]  lhs;
        logic [1:0]  rhs;
        logic [3:0]  alu;
        logic        wr, rr, wm, br;
        logic [2:0]  bc;
        logic        j, jm, wo;
        logic [2:0]  mw;
    } vec_t;

    vec_t v [12];

    pipelined_instruction_decoder #(.XLEN(32), .COUNT_WIDTH(4)) dut (
        .Clock(Clock), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(a_in_ready),
        .Instruction(Instruction), .InPC(pc[31:0]), .OutValid(a_out_valid), .OutReady(OutReady),
        .OutPC(a_pc), .OutRD(a_rd), .OutRS1(a_rs1), .OutRS2(a_rs2), .OutImmediate(a_imm),
        .OutLHSsource(a_lhs), .OutRHSsource(a_rhs), .OutALUOperation(a_alu), .OutWordOp(a_wo),
        .OutWritesRegisterFile(a_wr), .OutWritesRam(a_wm), .OutReadsRam(a_rr), .OutMemWidth(a_mw),
        .OutIsBranch(a_br), .OutBranchCondition(a_bc), .OutIsJump(a_j), .OutJumpMode(a_jm),
        .OutInvalid(a_inv), .InvalidCount(a_cnt)
    );

    pipelined_instruction_decoder #(.XLEN(64), .COUNT_WIDTH(16)) dut64 (
        .Clock(Clock), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(b_in_ready),
        .Instruction(Instruction), .InPC(pc), .OutValid(b_out_valid), .OutReady(OutReady),
        .OutPC(b_pc), .OutRD(b_rd), .OutRS1(b_rs1), .OutRS2(b_rs2), .OutImmediate(b_imm),
        .OutLHSsource(b_lhs), .OutRHSsource(b_rhs), .OutALUOperation(b_alu), .OutWordOp(b_wo),
        .OutWritesRegisterFile(b_wr), .OutWritesRam(b_wm), .OutReadsRam(b_rr), .OutMemWidth(b_mw),
        .OutIsBranch(b_br), .OutBranchCondition(b_bc), .OutIsJump(b_j), .OutJumpMode(b_jm),
        .OutInvalid(b_inv), .InvalidCount(b_cnt)
    );

    always #5 Clock = ~Clock;

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] p);
        InValid = 1'b1;
        Instruction = ins;
        pc = p;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0; Instruction = '0; pc = '0;
        cyc(); cyc();
        nvec++; if ({a_out_valid, a_in_ready, a_inv, a_wr, a_cnt, b_cnt} !== 24'h0) begin nfail++; $display("FAIL reset_state got %h want 0", {a_out_valid, a_in_ready, a_inv, a_wr, a_cnt, b_cnt}); end
        nvec++; if ({a_imm, a_rd, a_pc, b_imm} !== '0) begin nfail++; $display("FAIL reset_fields got %h/%h/%h want 0", a_imm, a_rd, a_pc); end
        Reset = 1'b0;
        cyc();
        nvec++; if ({a_in_ready, b_in_ready} !== 2'b11) begin nfail++; $display("FAIL reset_inready got %b want 11", {a_in_ready, b_in_ready}); end
    endtask

    task automatic test_addi();
        OutReady = 1'b1;
        send(32'hFFF00293, 64'h100);
        cyc();
        InValid = 1'b0;
        nvec++; if ({a_out_valid, b_out_valid} !== 2'b11) begin nfail++; $display("FAIL addi_valid got %b want 11", {a_out_valid, b_out_valid}); end
        nvec++; if (a_imm !== 32'hFFFFFFFF) begin nfail++; $display("FAIL addi_imm32 got %h want ffffffff", a_imm); end
        nvec++; if (b_imm !== 64'hFFFFFFFFFFFFFFFF) begin nfail++; $display("FAIL addi_imm64 got %h want all ones", b_imm); end
        nvec++; if ({a_rd, a_rhs, a_alu, a_wr, a_inv, a_pc} !== {5'd5, 2'd1, 4'd0, 1'b1, 1'b0, 32'h100}) begin nfail++; $display("FAIL addi_fields got rd=%0d rhs=%0d alu=%0d wr=%b inv=%b pc=%h", a_rd, a_rhs, a_alu, a_wr, a_inv, a_pc); end
        cyc();
        nvec++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL addi_drain got %b want 0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        OutReady = 1'b0;
        send(32'h00100093, 64'h10);
        cyc();
        nvec++; if ({a_out_valid, a_in_ready} !== 2'b11) begin nfail++; $display("FAIL b2b_first got %b want 11", {a_out_valid, a_in_ready}); end
        send(32'h00200113, 64'h14);
        cyc();
        nvec++; if ({a_out_valid, a_in_ready} !== 2'b10) begin nfail++; $display("FAIL b2b_second got %b want 10", {a_out_valid, a_in_ready}); end
        send(32'h00300193, 64'h18);
        cyc();
        nvec++; if ({a_in_ready, a_rd, a_pc} !== {1'b0, 5'd1, 32'h10}) begin nfail++; $display("FAIL b2b_hold got rdy=%b rd=%0d pc=%h want 0/1/10", a_in_ready, a_rd, a_pc); end
        OutReady = 1'b1;
        cyc();
        nvec++; if ({a_out_valid, a_in_ready, a_rd, a_pc} !== {1'b1, 1'b1, 5'd2, 32'h14}) begin nfail++; $display("FAIL b2b_skid got v=%b rdy=%b rd=%0d pc=%h want 1/1/2/14", a_out_valid, a_in_ready, a_rd, a_pc); end
        cyc();
        InValid = 1'b0;
        nvec++; if ({a_out_valid, a_rd, a_pc} !== {1'b1, 5'd3, 32'h18}) begin nfail++; $display("FAIL b2b_third got v=%b rd=%0d pc=%h want 1/3/18", a_out_valid, a_rd, a_pc); end
        cyc();
        nvec++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL b2b_empty got %b want 0", a_out_valid); end
    endtask

    task automatic test_flush();
        OutReady = 1'b0;
        send(32'h00100093, 64'h20);
        cyc();
        send(32'h00200113, 64'h24);
        cyc();
        nvec++; if (a_in_ready !== 1'b0) begin nfail++; $display("FAIL flush_full got %b want 0", a_in_ready); end
        Flush = 1'b1;
        send(32'h0, 64'h28);
        cyc();
        Flush = 1'b0; InValid = 1'b0;
        nvec++; if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin nfail++; $display("FAIL flush_clear got %b want 0101", {a_out_valid, a_in_ready, b_out_valid, b_in_ready}); end
        Flush = 1'b1;
        send(32'h0, 64'h30);
        cyc();
        Flush = 1'b0; InValid = 1'b0;
        nvec++; if ({a_out_valid, a_cnt} !== 5'h0) begin nfail++; $display("FAIL flush_drop got v=%b cnt=%0d want 0/0", a_out_valid, a_cnt); end
        OutReady = 1'b1;
        cyc(); cyc();
        nvec++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL flush_silent got %b want 0", a_out_valid); end
    endtask

    task automatic test_invalid();
        OutReady = 1'b1;
        send(32'h00000000, 64'h40);
        cyc();
        nvec++; if ({a_out_valid, a_inv, a_wr, a_wm, a_rr, a_br, a_j} !== 7'b1100000) begin nfail++; $display("FAIL inv_zero got %b want 1100000", {a_out_valid, a_inv, a_wr, a_wm, a_rr, a_br, a_j}); end
        nvec++; if ({a_cnt, b_cnt} !== {4'd1, 16'd1}) begin nfail++; $display("FAIL inv_count got %0d/%0d want 1/1", a_cnt, b_cnt); end
        send(32'h00208033, 64'h44);
        cyc();
        InValid = 1'b0;
        nvec++; if ({a_inv, a_wr, a_rs1, a_rs2, a_alu, a_cnt} !== {1'b0, 1'b0, 5'd1, 5'd2, 4'd0, 4'd1}) begin nfail++; $display("FAIL inv_add_x0 got inv=%b wr=%b rs1=%0d rs2=%0d alu=%0d cnt=%0d", a_inv, a_wr, a_rs1, a_rs2, a_alu, a_cnt); end
        cyc();
    endtask

    task automatic test_xlen();
        OutReady = 1'b1;
        send(32'h0000B083, 64'h50);
        cyc();
        InValid = 1'b0;
        nvec++; if ({b_inv, b_rr, b_wr, b_mw} !== {1'b0, 1'b1, 1'b1, 3'd3}) begin nfail++; $display("FAIL ld_rv64 got inv=%b rr=%b wr=%b mw=%0d want 0/1/1/3", b_inv, b_rr, b_wr, b_mw); end
        nvec++; if ({a_inv, a_rr, a_wr, a_cnt, b_cnt} !== {1'b1, 1'b0, 1'b0, 4'd2, 16'd1}) begin nfail++; $display("FAIL ld_rv32 got inv=%b rr=%b wr=%b cnt=%0d/%0d want 1/0/0/2/1", a_inv, a_rr, a_wr, a_cnt, b_cnt); end
        cyc();
    endtask

    task automatic test_classes();
        v[0]  = '{32'h800002B7, 1'b0, 1'b0, 32'h80000000, 3'd1, 2'd1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        v[1]  = '{32'hFFDFF0EF, 1'b0, 1'b0, 32'hFFFFFFFC, 3'd4, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        v[2]  = '{32'h000100E7, 1'b0, 1'b0, 32'h00000000, 3'd4, 2'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0};
        v[3]  = '{32'h0020C463, 1'b0, 1'b0, 32'h00000008, 3'd0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0};
        v[4]  = '{32'h0020A463, 1'b1, 1'b1, 32'h00000000, 3'd0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        v[5]  = '{32'h0020A223, 1'b0, 1'b0, 32'h00000004, 3'd0, 2'd1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2};
        v[6]  = '{32'h4030D093, 1'b0, 1'b0, 32'h00000403, 3'd0, 2'd1, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        v[7]  = '{32'h02009093, 1'b1, 1'b0, 32'h00000020, 3'd0, 2'd1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        v[8]  = '{32'h402081B3, 1'b0, 1'b0, 32'h00000000, 3'd0, 2'd0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        v[9]  = '{32'h4020F1B3, 1'b1, 1'b1, 32'h00000000, 3'd0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        v[10] = '{32'h002081BB, 1'b1, 1'b0, 32'h00000000, 3'd0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0};
        v[11] = '{32'h00001097, 1'b0, 1'b0, 32'h00001000, 3'd4, 2'd1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        OutReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(v[i].ins, 64'h200 + 64'(4 * i));
            cyc();
            nvec++; if ({a_out_valid, a_inv, b_inv} !== {1'b1, v[i].ainv, v[i].binv}) begin nfail++; $display("FAIL cls%0d_inv got %b want %b", i, {a_out_valid, a_inv, b_inv}, {1'b1, v[i].ainv, v[i].binv}); end
            if (v[i].binv) begin
                nvec++; if ({b_wr, b_rr, b_wm, b_br, b_j} !== 5'b0) begin nfail++; $display("FAIL cls%0d_kill got %b want 00000", i, {b_wr, b_rr, b_wm, b_br, b_j}); end
            end else begin
                nvec++; if ({b_imm, b_lhs, b_rhs, b_alu, b_wr, b_rr, b_wm, b_br, b_j, b_wo} !== {{32{v[i].imm[31]}}, v[i].imm, v[i].lhs, v[i].rhs, v[i].alu, v[i].wr, v[i].rr, v[i].wm, v[i].br, v[i].j, v[i].wo}) begin
                    nfail++; $display("FAIL cls%0d_fields got imm=%h lhs=%0d rhs=%0d alu=%h en=%b want imm=%h lhs=%0d rhs=%0d alu=%h en=%b", i, b_imm, b_lhs, b_rhs, b_alu, {b_wr, b_rr, b_wm, b_br, b_j, b_wo}, v[i].imm, v[i].lhs, v[i].rhs, v[i].alu, {v[i].wr, v[i].rr, v[i].wm, v[i].br, v[i].j, v[i].wo});
                end
                if (v[i].br) begin
                    nvec++; if (b_bc !== v[i].bc) begin nfail++; $display("FAIL cls%0d_cond got %0d want %0d", i, b_bc, v[i].bc); end
                end
                if (v[i].j) begin
                    nvec++; if (b_jm !== v[i].jm) begin nfail++; $display("FAIL cls%0d_jmode got %b want %b", i, b_jm, v[i].jm); end
                end
                if (v[i].rr || v[i].wm) begin
                    nvec++; if (b_mw !== v[i].mw) begin nfail++; $display("FAIL cls%0d_width got %0d want %0d", i, b_mw, v[i].mw); end
                end
            end
        end
        InValid = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        OutReady = 1'b0;
        send(32'h00100093, 64'h60);
        cyc();
        send(32'h00200113, 64'h64);
        cyc();
        InValid = 1'b0;
        Reset = 1'b1;
        #1;
        nvec++; if ({a_out_valid, a_in_ready} !== 2'b00) begin nfail++; $display("FAIL rstmid_async got %b want 00", {a_out_valid, a_in_ready}); end
        cyc();
        Reset = 1'b0;
        cyc();
        nvec++; if ({a_out_valid, a_in_ready, a_cnt} !== {1'b0, 1'b1, 4'd0}) begin nfail++; $display("FAIL rstmid_after got v=%b rdy=%b cnt=%0d want 0/1/0", a_out_valid, a_in_ready, a_cnt); end
        OutReady = 1'b1;
        cyc();
        nvec++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL rstmid_silent got %b want 0", a_out_valid); end
    endtask

    task automatic test_saturation();
        OutReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(32'h0, 64'h300 + 64'(4 * i));
            cyc();
            if (i == 13) begin
                nvec++; if (a_cnt !== 4'd14) begin nfail++; $display("FAIL sat_14 got %0d want 14", a_cnt); end
            end
            if (i == 14) begin
                nvec++; if (a_cnt !== 4'd15) begin nfail++; $display("FAIL sat_15 got %0d want 15", a_cnt); end
            end
        end
        InValid = 1'b0;
        nvec++; if ({a_cnt, b_cnt} !== {4'd15, 16'd20}) begin nfail++; $display("FAIL sat_20 got %0d/%0d want 15/20", a_cnt, b_cnt); end
        cyc();
        nvec++; if (a_cnt !== 4'd15) begin nfail++; $display("FAIL sat_hold got %0d want 15", a_cnt); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_flush();
        test_invalid();
        test_xlen();
        test_classes();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
